// File: rtl/vga_row_scheduler.sv
// vga_row_scheduler
//   Time-shares one register-row renderer across N_ROWS CPU register sources.
//   All sources are snapshotted at frame start, so a frame shows one coherent
//   CPU state. The scheduler follows the raster line and presents the active
//   row's byte, index and first raster line to the renderer.
//
// Parameters
//   N_ROWS     number of sources / display rows (1..16)
//   START_V    first raster line of row 0
//   ROW_PITCH  raster lines per row (>=2)
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   vga_v         current raster line
//   vga_h         current pixel column (not used by the logic)
//   regs_in       packed sources, row i = regs_in[8*i+7:8*i]
//   freeze        hold the current snapshot at frame start
//   snap_req      pulse: capture at the next frame start even when frozen
//   snap_done     one-cycle pulse after a snapshot is taken
//   row_active    1 while the raster is inside a row band
//   row_index     active row index (0 outside a band)
//   row_start_v   first line of the active row (0 outside a band)
//   row_data      snapshot byte of the active row (0 outside a band)
//   frame_count   frames seen since reset, wraps 255->0
//   row_changed   (VGA_ROW_CHANGE_HL_EN only) active row byte differs from
//                 the previous snapshot
//
// Optional feature macro: VGA_ROW_CHANGE_HL_EN adds row_changed and a second
// snapshot bank holding the previous capture.

module vga_row_scheduler #(
    parameter int N_ROWS    = 7,
    parameter int START_V   = 10,
    parameter int ROW_PITCH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [10:0]         vga_v,
    input  logic [10:0]         vga_h,
    input  logic [8*N_ROWS-1:0] regs_in,
    input  logic                freeze,
    input  logic                snap_req,
    output logic                snap_done,
    output logic                row_active,
    output logic [3:0]          row_index,
    output logic [10:0]         row_start_v,
    output logic [7:0]          row_data,
    output logic [7:0]          frame_count
`ifdef VGA_ROW_CHANGE_HL_EN
    ,
    output logic                row_changed
`endif
);

    localparam int LC_W = $clog2(ROW_PITCH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                   state, state_n;
    logic [10:0]              vga_v_q;
    logic                     new_line, frame_start, capture;
    logic                     pend;
    // Cleared by reset, set by the first frame start: a reset mid-frame
    // must not display anything until the raster wraps to line 0.
    logic                     armed;
    logic [LC_W-1:0]          line_cnt, line_cnt_n;
    logic [3:0]               cur_row, cur_row_n;
    logic [10:0]              cur_start, cur_start_n;
    logic [N_ROWS-1:0][7:0]   snap;
    logic [15:0][7:0]         snap_ext;
    logic                     active_n;
    logic                     unused_h;

    assign unused_h = ^vga_h;

    assign new_line    = (vga_v != vga_v_q);
    assign frame_start = new_line && (vga_v == 11'd0);
    // A snap_req landing in the frame-start cycle captures immediately.
    assign capture     = frame_start && (!freeze || pend || snap_req);

    // Pad the snapshot to 16 entries so the 4-bit row index selects cleanly.
    for (genvar g = 0; g < 16; g++) begin : g_ext
        if (g < N_ROWS) begin : g_row
            assign snap_ext[g] = snap[g];
        end else begin : g_pad
            assign snap_ext[g] = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        line_cnt_n  = line_cnt;
        cur_row_n   = cur_row;
        cur_start_n = cur_start;
        if (frame_start) begin
            state_n = IDLE;
        end else if (new_line) begin
            case (state)
                IDLE: begin
                    if (armed && vga_v == 11'(START_V)) begin
                        state_n     = ACTIVE;
                        cur_row_n   = 4'd0;
                        line_cnt_n  = '0;
                        cur_start_n = 11'(START_V);
                    end
                end
                ACTIVE: begin
                    if (line_cnt == LC_W'(ROW_PITCH - 1)) begin
                        if (cur_row == 4'(N_ROWS - 1)) begin
                            state_n = DONE;
                        end else begin
                            cur_row_n   = cur_row + 4'd1;
                            cur_start_n = cur_start + 11'(ROW_PITCH);
                            line_cnt_n  = '0;
                        end
                    end else begin
                        line_cnt_n = line_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign active_n = (state_n == ACTIVE);

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_v_q     <= '0;
            armed       <= 1'b0;
            pend        <= 1'b0;
            line_cnt    <= '0;
            cur_row     <= '0;
            cur_start   <= '0;
            snap        <= '0;
            snap_done   <= 1'b0;
            frame_count <= '0;
            row_active  <= 1'b0;
            row_index   <= '0;
            row_start_v <= '0;
            row_data    <= '0;
        end else begin
            vga_v_q   <= vga_v;
            line_cnt  <= line_cnt_n;
            cur_row   <= cur_row_n;
            cur_start <= cur_start_n;
            if (frame_start) begin
                armed       <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
            if (capture) begin
                snap <= regs_in;
                pend <= 1'b0;
            end else if (snap_req) begin
                pend <= 1'b1;
            end
            snap_done   <= capture;
            // Capture only happens on frame start, which forces IDLE, so the
            // pre-capture snapshot is never shown on an active row here.
            row_active  <= active_n;
            row_index   <= active_n ? cur_row_n   : 4'd0;
            row_start_v <= active_n ? cur_start_n : 11'd0;
            row_data    <= active_n ? snap_ext[cur_row_n] : 8'h00;
        end
    end

`ifdef VGA_ROW_CHANGE_HL_EN
    logic [N_ROWS-1:0][7:0] prev;
    logic [15:0][7:0]       prev_ext;

    for (genvar g = 0; g < 16; g++) begin : g_pext
        if (g < N_ROWS) begin : g_row
            assign prev_ext[g] = prev[g];
        end else begin : g_pad
            assign prev_ext[g] = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= '0;
            row_changed <= 1'b0;
        end else begin
            if (capture) prev <= snap;
            row_changed <= active_n && (snap_ext[cur_row_n] != prev_ext[cur_row_n]);
        end
    end
`endif

endmodule
